// File: rtl/odata_framer_pkg.sv
// odata_framer_pkg: shared types, constants and helpers for the odata AXIS framer
package odata_framer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        PAD    = 2'd2
    } state_t;

    localparam int CNT_W = 16;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/framer_sfifo.sv
// framer_sfifo: synchronous first-word-fall-through FIFO, head word always on rd_data
module framer_sfifo
    import odata_framer_pkg::*;
#(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int AW        = ptr_w(FIFO_DEPTH)
) (
    input  logic          sys_clock,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_wr, do_rd;

    assign empty   = count_q == '0;
    assign full    = count_q == (AW+1)'(FIFO_DEPTH);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    // Pointers wrap naturally because the depth is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    // Pointer and occupancy registers
    always_ff @(posedge sys_clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge sys_clock) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/odata_axis_framer.sv
// odata_axis_framer: buffers a non-stallable word stream and emits fixed-length AXIS frames
module odata_axis_framer
    import odata_framer_pkg::*;
#(
    parameter int            DW         = 8,
    parameter int            FRAME_LEN  = 16,
    parameter int            FIFO_DEPTH = 16,
    parameter logic [DW-1:0] PAD_VALUE  = '0
) (
    input  logic             sys_clock,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic [DW-1:0]    m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    localparam int BW = $clog2(FRAME_LEN);
    localparam int AW = ptr_w(FIFO_DEPTH);

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [DW-1:0]    fifo_rd_data;
    logic             fifo_empty, fifo_full;
    logic [AW:0]      unused_count;
    logic             in_ok, xfer, last_beat;

    assign in_ok     = in_valid && enable && state_q == STREAM;
    assign xfer      = m_tvalid && m_tready;
    assign last_beat = beat_q == BW'(FRAME_LEN - 1);
    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;

    framer_sfifo #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clock (sys_clock),
        .rst_n     (rst_n),
        .wr_en     (in_ok && !fifo_full),
        .wr_data   (in_data),
        .rd_en     (xfer && state_q == STREAM),
        .rd_data   (fifo_rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (unused_count)
    );

    // Output mux: FIFO head while streaming, constant pad word while padding, zero otherwise
    always_comb begin
        m_tvalid = (state_q == STREAM && !fifo_empty) || state_q == PAD;
        m_tdata  = state_q == PAD ? PAD_VALUE : ((state_q == STREAM && !fifo_empty) ? fifo_rd_data : '0);
        m_tlast  = last_beat && m_tvalid;
        busy     = state_q != IDLE;
    end

    // Next state: drain the FIFO after enable falls, then pad out any partial frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = STREAM;
            STREAM:  if (!enable && fifo_empty) state_d = (beat_q == '0) ? IDLE : PAD;
            PAD:     if (xfer && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat position, completed-frame count and saturating drop count
    always_comb begin
        beat_d  = xfer ? (last_beat ? '0 : beat_q + BW'(1)) : beat_q;
        frame_d = frame_q + CNT_W'(xfer && last_beat);
        drop_d  = (in_ok && fifo_full && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
    end

    // Control registers
    always_ff @(posedge sys_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            frame_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            frame_q <= frame_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: doc/odata_axis_framer.md
Name: odata_axis_framer

Overview:
Consumes the free-running raw data stream (`odata`-style word plus valid strobe) produced by the top-level data source. Buffers it in a small FIFO and packs it into fixed-length AXI4-Stream frames with `tlast` on every FRAME_LEN-th beat. The source cannot be stalled: overflow is dropped and counted. A partial frame left when `enable` falls is completed with PAD_VALUE beats, so downstream always sees whole frames.

Parameters:
DW, 8, data width of input word and m_tdata
FRAME_LEN, 16, beats per frame (>=2)
FIFO_DEPTH, 16, buffer depth in words (power of 2, >=4)
PAD_VALUE, 0, DW-bit word emitted when padding a partial frame

Ports:
sys_clock  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  level; 1 = accept and frame data, 0 = finish current frame then idle
in_data  input  DW  raw data word from upstream source
in_valid  input  1  in_data valid this cycle (no backpressure possible)
m_tdata  output  DW  AXIS data
m_tvalid  output  1  AXIS valid
m_tready  input  1  AXIS ready
m_tlast  output  1  last beat of frame
frame_cnt  output  16  completed frames (wraps)
drop_cnt  output  16  dropped input words (saturates at 16'hFFFF)
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n=0, async): state=IDLE, FIFO empty, beat=0, m_tvalid=0, m_tlast=0, m_tdata=0, frame_cnt=0, drop_cnt=0, busy=0.
- Handshake: beat transfers when m_tvalid&&m_tready. Once m_tvalid=1, m_tdata/m_tlast stay stable until transfer (FIFO head is stable; pad word is constant).
- FIFO write: in_valid && state==STREAM && enable && !full. Full is evaluated on the registered count; a same-cycle pop does not free space for the write.
- If in_valid && state==STREAM && enable && full: word is dropped and drop_cnt increments, saturating.
- In IDLE or PAD, or when enable=0: input is ignored and not counted.
- Latency: word written at edge t is visible on m_tdata with m_tvalid=1 from cycle t+1 (FWFT, no bypass).
- beat counter runs 0..FRAME_LEN-1. It increments on each transfer and wraps to 0 after the tlast transfer. m_tlast = (beat==FRAME_LEN-1) && m_tvalid.
- frame_cnt increments on each tlast transfer, wrapping 16'hFFFF -> 0.
- States:
  - IDLE: m_tvalid=0. enable=1 -> STREAM next cycle.
  - STREAM: m_tvalid = !fifo_empty; m_tdata = FIFO head. Transitions when enable=0:
    - FIFO non-empty: keep draining (frames continue to form).
    - FIFO empty and beat==0: -> IDLE.
    - FIFO empty and beat!=0: -> PAD.
    - enable re-asserting while still STREAM resumes normal writes.
  - PAD: m_tvalid=1, m_tdata=PAD_VALUE. Stays until the tlast transfer, then -> IDLE. enable is ignored until IDLE is reached; it is then sampled again next cycle.
- Simultaneous push and pop: count unchanged, head advances. Push while empty: the word appears next cycle only.
- m_tready held low indefinitely: FIFO fills, further words are dropped, and no output changes.
- Reset mid-frame: everything is cleared immediately. No partial-frame recovery; downstream must also be in reset.

Decomposition:
- Package odata_framer_pkg holds:
  - state enum (IDLE, STREAM, PAD), 2-bit;
  - CNT_W=16 localparam;
  - helper function clog2-based FIFO pointer width.
- Sub-module framer_sfifo: synchronous FWFT FIFO (DW, FIFO_DEPTH) with ports wr_en, wr_data, rd_en, rd_data, empty, full, count. Uses the same clock and reset names.
- The top module holds the FSM, beat and frame counters, drop logic and output mux.

Test Plan:
1. FRAME_LEN=16, enable=1, m_tready=1, in_valid every cycle, data 0..47 -> 3 frames. Transfers carry 0..47 in order, tlast on 15/31/47. frame_cnt=3, drop_cnt=0, first m_tvalid one cycle after first write.
2. Write 21 words then enable=0 -> beats 0..20, then 11 PAD_VALUE beats with tlast on the 32nd. frame_cnt=2, then busy=0.
3. m_tready=0, 40 words with FIFO_DEPTH=16 -> 16 stored, drop_cnt=24. Release tready: exactly words 0..15 emitted, one frame.
4. Random m_tready (50%), in_valid 30%, 1000 words -> scoreboard exact order, no gaps. tdata/tlast stable while tvalid&&!tready.
5. Assert rst_n=0 mid-frame at beat 7 with FIFO holding 5 words -> outputs zero asynchronously. After release with enable=1, the next frame starts at beat 0 with fresh data.
6. drop_cnt preset near saturation (70000 drops under tready=0) -> holds at 16'hFFFF. enable toggled 0 in PAD state has no effect until IDLE.
